rnd_share_arbiter: RTL and testbench

Shares one internal 4-bit Fibonacci LFSR random source among NUM_REQ requesters.
- Round-robin arbitration picks one requester at a time.
- Before delivery, the LFSR is advanced SHIFTS times so each grant gets a freshly mixed value.
- Sits between the random generator and game/test logic that needs independent random draws.

---
 rtl/rnd_share_arbiter.sv | 122 ++++++++++++
 tb/tb_rnd_share_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rnd_share_arbiter.sv
// rtl/rnd_share_arbiter.sv - round-robin sharing of one free-running Fibonacci LFSR among NUM_REQ requesters
// Define RND_NO_REPEAT_EN to hold MIX one extra cycle whenever the draw would repeat the last delivered value.
module rnd_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int SHIFTS  = 3,
   parameter int SEED    = 13
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [WIDTH-1:0]   rnd_out,
   output logic               rnd_valid,
   output logic               busy
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
   localparam logic [CW-1:0] COUNT_LAST = CW'(SHIFTS - 1);
   localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, MIX, DELIVER} state_t;

   state_t             state;
   state_t             state_nx;
   logic [WIDTH-1:0]   lfsr;
   logic [WIDTH-1:0]   lfsr_nx;
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ptr_nx;
   logic [PW-1:0]      winner;
   logic [PW-1:0]      winner_nx;
   logic [PW-1:0]      pick;
   logic [PW-1:0]      scan_idx;
   logic [CW-1:0]      count;
   logic [CW-1:0]      count_nx;
   logic [NUM_REQ-1:0] gnt_nx;
   logic [WIDTH-1:0]   rnd_nx;
   logic               valid_nx;
   logic               found;
   logic               repeat_hit;

   assign lfsr_nx = {lfsr[WIDTH-2:0], lfsr[WIDTH-1] ^ lfsr[WIDTH-2]};
   assign busy    = (state != IDLE);

`ifdef RND_NO_REPEAT_EN
   assign repeat_hit = (lfsr == rnd_out);
`else
   assign repeat_hit = 1'b0;
`endif

   // First requester at or after ptr, wrapping around.
   always_comb begin
      found    = 1'b0;
      pick     = ptr;
      scan_idx = ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[scan_idx]) begin
            found = 1'b1;
            pick  = scan_idx;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      winner_nx = winner;
      count_nx  = count;
      gnt_nx    = '0;
      valid_nx  = 1'b0;
      rnd_nx    = rnd_out;
      case (state)
         IDLE: begin
            if (found) begin
               winner_nx = pick;
               count_nx  = '0;
               state_nx  = MIX;
            end
         end
         MIX: begin
            if (count != COUNT_LAST) begin
               count_nx = count + CW'(1);
            end else if (!repeat_hit) begin
               rnd_nx   = lfsr;
               gnt_nx   = NUM_REQ'(1) << winner;
               valid_nx = 1'b1;
               state_nx = DELIVER;
            end
         end
         DELIVER: begin
            ptr_nx   = (winner == PTR_LAST) ? '0 : winner + PW'(1);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         lfsr      <= WIDTH'(SEED);
         ptr       <= '0;
         winner    <= '0;
         count     <= '0;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         rnd_out   <= '0;
      end else begin
         state     <= state_nx;
         lfsr      <= lfsr_nx;
         ptr       <= ptr_nx;
         winner    <= winner_nx;
         count     <= count_nx;
         gnt       <= gnt_nx;
         rnd_valid <= valid_nx;
         rnd_out   <= rnd_nx;
      end
   end

endmodule

// File: tb/tb_rnd_share_arbiter.sv
// tb/tb_rnd_share_arbiter.sv - vector table, corner sequences and random checks for rnd_share_arbiter
module tb_rnd_share_arbiter;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int SH = 3;
   localparam int SD = 13;

`ifdef RND_NO_REPEAT_EN
   localparam int NR_EDGE = 20;
   localparam int NR_RND  = 7;
`else
   localparam int NR_EDGE = 19;
   localparam int NR_RND  = 11;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] req   = '0;
   logic [N-1:0] gnt;
   logic [W-1:0] rnd_out;
   logic         rnd_valid;
   logic         busy;

   always #5 clock = ~clock;

   rnd_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .SHIFTS(SH), .SEED(SD)) dut (
      .clock(clock),
      .reset(reset),
      .req(req),
      .gnt(gnt),
      .rnd_out(rnd_out),
      .rnd_valid(rnd_valid),
      .busy(busy)
   );

   typedef struct {
      logic         rst;
      logic [N-1:0] rq;
      logic [N-1:0] g;
      logic         v;
      logic [W-1:0] r;
      logic         b;
   } vec_t;

   vec_t vecs[23];

   int total = 0;
   int bad   = 0;

   // Timeline model: LFSR value before post-reset edge e is seq[(e-1) mod 15].
   int           seq[15];
   int           n_m;
   bit           draw_m;
   int           del_m;
   int           w_m;
   int           ptr_m;
   int           last_m;
   logic [N-1:0] prev_gnt;
   int           grants[$];
   int           grant_edge;

   function automatic int seq_at(input int e);
      return seq[(e - 1) % 15];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] q);
      int           idx;
      logic [N-1:0] exp_g;
      reset = r;
      req   = q;
      @(posedge clock);
      if (r) begin
         n_m    = 0;
         draw_m = 0;
         del_m  = -1;
         ptr_m  = 0;
         last_m = 0;
      end else begin
         n_m++;
         if (draw_m) begin
            if (n_m == del_m) begin
               last_m = seq_at(n_m);
            end else if (n_m == del_m + 1) begin
               draw_m = 0;
               ptr_m  = (w_m + 1) % N;
            end
         end else if (q != '0) begin
            w_m = -1;
            for (int i = 0; i < N; i++) begin
               idx = (ptr_m + i) % N;
               if (w_m < 0 && q[idx]) w_m = idx;
            end
            del_m = n_m + SH;
`ifdef RND_NO_REPEAT_EN
            if (seq_at(del_m) == last_m) del_m++;
`endif
            draw_m = 1;
         end
      end
      @(negedge clock);
      exp_g = (draw_m && n_m == del_m) ? (N'(1) << w_m) : '0;
      check("m_gnt", 32'(gnt), 32'(exp_g));
      check("m_valid", 32'(rnd_valid), 32'(exp_g != '0));
      check("m_rnd", 32'(rnd_out), 32'(last_m));
      check("m_busy", 32'(busy), 32'(draw_m));
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("no_b2b", 32'(prev_gnt != '0 && gnt != '0), 32'd0);
      if (gnt != '0) begin
         grants.push_back($clog2(gnt));
         grant_edge = n_m;
      end
      prev_gnt = gnt;
   endtask

   initial begin
      seq[0] = SD;
      for (int i = 1; i < 15; i++)
         seq[i] = ((seq[i-1] * 2) % 16) + (((seq[i-1] / 8) + (seq[i-1] / 4)) % 2);
      n_m = 0; draw_m = 0; del_m = -1; w_m = 0; ptr_m = 0; last_m = 0;
      prev_gnt = '0; grant_edge = -1;

      // single requester, then two requesters held continuously
      vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0,  1'b0};
      vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'd0,  1'b1};
      vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'd0,  1'b1};
      vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 4'd0,  1'b1};
      vecs[4]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'd11, 1'b1};
      vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'd11, 1'b0};
      vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'd11, 1'b0};
      vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0,  1'b0};
      vecs[8]  = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd0,  1'b1};
      vecs[9]  = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd0,  1'b1};
      vecs[10] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd0,  1'b1};
      vecs[11] = '{1'b0, 4'b0101, 4'b0001, 1'b1, 4'd11, 1'b1};
      vecs[12] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd11, 1'b0};
      vecs[13] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd11, 1'b1};
      vecs[14] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd11, 1'b1};
      vecs[15] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd11, 1'b1};
      vecs[16] = '{1'b0, 4'b0101, 4'b0100, 1'b1, 4'd8,  1'b1};
      vecs[17] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd8,  1'b0};
      vecs[18] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd8,  1'b1};
      vecs[19] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd8,  1'b1};
      vecs[20] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'd8,  1'b1};
      vecs[21] = '{1'b0, 4'b0101, 4'b0001, 1'b1, 4'd3,  1'b1};
      vecs[22] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'd3,  1'b0};

      for (int k = 0; k < 23; k++) begin
         step(vecs[k].rst, vecs[k].rq);
         check($sformatf("t_gnt[%0d]", k), 32'(gnt), 32'(vecs[k].g));
         check($sformatf("t_valid[%0d]", k), 32'(rnd_valid), 32'(vecs[k].v));
         check($sformatf("t_rnd[%0d]", k), 32'(rnd_out), 32'(vecs[k].r));
         check($sformatf("t_busy[%0d]", k), 32'(busy), 32'(vecs[k].b));
      end

      // reset in MIX restores ptr and lfsr
      step(1'b1, 4'b0000);
      repeat (4) step(1'b0, 4'b0001);
      step(1'b0, 4'b0000);
      step(1'b0, 4'b1001);
      step(1'b0, 4'b1001);
      step(1'b1, 4'b1001);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(rnd_valid), 32'd0);
      check("rst_rnd", 32'(rnd_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (4) step(1'b0, 4'b1001);
      check("rst_regnt", 32'(gnt), 32'b0001);
      check("rst_rernd", 32'(rnd_out), 32'd11);

      // one-cycle request pulse
      step(1'b1, 4'b0000);
      step(1'b0, 4'b0010);
      repeat (3) step(1'b0, 4'b0000);
      check("pulse_gnt", 32'(gnt), 32'b0010);
      repeat (6) step(1'b0, 4'b0000);
      check("pulse_idle", 32'(busy), 32'd0);

      // all requesting for eight draws
      step(1'b1, 4'b0000);
      grants.delete();
      repeat (40) step(1'b0, 4'b1111);
      check("rr_count", 32'(grants.size()), 32'd8);
      for (int k = 0; k < 8 && k < grants.size(); k++)
         check($sformatf("rr_order[%0d]", k), 32'(grants[k]), 32'(k % 4));

      // idle gap of 15 cycles lines the next draw up on the last value
      step(1'b1, 4'b0000);
      repeat (4) step(1'b0, 4'b0001);
      repeat (11) step(1'b0, 4'b0000);
      step(1'b0, 4'b0001);
      grant_edge = -1;
      repeat (6) step(1'b0, 4'b0000);
      check("nr_edge", 32'(grant_edge), 32'(NR_EDGE));
      check("nr_rnd", 32'(rnd_out), 32'(NR_RND));

      // random traffic against the timeline model
      step(1'b1, 4'b0000);
      repeat (2000) begin
         logic         r;
         logic [N-1:0] q;
         r = ($urandom_range(99) == 0);
         q = ($urandom_range(3) == 0) ? '0 : N'($urandom_range(15));
         step(r, q);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
